// File: rtl/audio_spi_reg_engine_if.sv
// Host command/response bus for the codec SPI register engine.
// master = system control logic, slave = audio_spi_reg_engine.
interface audio_spi_reg_engine_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              iCMD_VALID;
  logic              oCMD_READY;
  logic              iCMD_RW;
  logic [ADDR_W-1:0] iCMD_ADDR;
  logic [DATA_W-1:0] iCMD_WDATA;
  logic              oRSP_VALID;
  logic [DATA_W-1:0] oRSP_RDATA;

  modport master (
    output iCMD_VALID, iCMD_RW, iCMD_ADDR, iCMD_WDATA,
    input  oCMD_READY, oRSP_VALID, oRSP_RDATA
  );

  modport slave (
    input  iCMD_VALID, iCMD_RW, iCMD_ADDR, iCMD_WDATA,
    output oCMD_READY, oRSP_VALID, oRSP_RDATA
  );
endinterface

// File: rtl/audio_spi_reg_engine.sv
// SPI mode-3 master that walks a codec register table from a sync ROM and serves host commands.
// Optional readback check of every table write is enabled by defining VERIFY_EN.
module audio_spi_reg_engine #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 128,
  parameter int IDX_W     = 8,
  parameter int CLK_DIV   = 62,
  parameter int GAP_TICKS = 2
) (
  input  logic                     iCLK_50,
  input  logic                     iRESET_n,
  input  logic                     iSTART,
  output logic [IDX_W-1:0]         oROM_ADDR,
  input  logic [ADDR_W+DATA_W-1:0] iROM_DATA,
  audio_spi_reg_engine_if.slave    cmd,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic                     oERR,
  output logic [IDX_W-1:0]         oERR_IDX,
  output logic                     oCS_n,
  output logic                     oSCLK,
  output logic                     oDIN,
  input  logic                     iDOUT
);
  localparam int FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int ENT_W   = ADDR_W + DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ROM_REQ  = 4'd1;
  localparam logic [3:0] S_ROM_WAIT = 4'd2;
  localparam logic [3:0] S_LOAD     = 4'd3;
  localparam logic [3:0] S_CS_SETUP = 4'd4;
  localparam logic [3:0] S_SHIFT_LO = 4'd5;
  localparam logic [3:0] S_SHIFT_HI = 4'd6;
  localparam logic [3:0] S_CS_HOLD  = 4'd7;
  localparam logic [3:0] S_GAP      = 4'd8;
  localparam logic [3:0] S_NEXT     = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  logic [3:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wait_q, wait_d;
  logic [ENT_W-1:0]   ent_q, ent_d;
  logic               rd_q, rd_d;
  logic               cmd_q, cmd_d;
  logic               ret_done_q, ret_done_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic               tick;
  logic               idle_like;
  logic               accept;
  logic [FRAME_W-1:0] frame;

  assign tick      = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // A walk request in the same cycle takes priority; the command stays pending.
  assign accept    = idle_like && !iSTART && cmd.iCMD_VALID;

  // Read frames carry an all-ones data field.
  assign frame = rd_q ? {ent_q[ENT_W-1:DATA_W], 1'b1, {DATA_W{1'b1}}}
                      : {ent_q[ENT_W-1:DATA_W], 1'b0, ent_q[DATA_W-1:0]};

  // Divider restarts at frame load so CS_SETUP lasts exactly one tick.
  always_comb begin
    div_d = div_q + 1'b1;
    if (!busy_q || state_q == S_LOAD || tick) div_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    ent_d       = ent_q;
    rd_d        = rd_q;
    cmd_d       = cmd_q;
    ret_done_d  = ret_done_q;
    sr_d        = sr_q;
    cap_d       = cap_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (iSTART) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          cmd_d     = 1'b0;
          rd_d      = 1'b0;
          state_d   = S_ROM_REQ;
        end else if (accept) begin
          ent_d      = {cmd.iCMD_ADDR, cmd.iCMD_WDATA};
          rd_d       = cmd.iCMD_RW;
          cmd_d      = 1'b1;
          ret_done_d = (state_q == S_DONE);
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_ROM_REQ: begin
        wait_d  = 1'b0;
        state_d = S_ROM_WAIT;
      end
      S_ROM_WAIT: begin
        if (wait_q) begin
          ent_d   = iROM_DATA;
          state_d = S_LOAD;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_LOAD: begin
        sr_d    = frame;
        din_d   = frame[FRAME_W-1];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b1;
        bit_d   = '0;
        state_d = S_CS_SETUP;
      end
      S_CS_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sclk_d  = 1'b1;
          cap_d   = {cap_q[DATA_W-2:0], iDOUT};
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = S_CS_HOLD;
          end else begin
            sclk_d  = 1'b0;
            sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
            din_d   = sr_q[FRAME_W-2];
            bit_d   = bit_q + 1'b1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_CS_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            if (cmd_q) begin
              busy_d  = 1'b0;
              cmd_d   = 1'b0;
              state_d = ret_done_q ? S_DONE : S_IDLE;
              if (rd_q) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = cap_q;
              end
`ifdef VERIFY_EN
            end else if (!rd_q) begin
              rd_d    = 1'b1;
              state_d = S_LOAD;
            end else begin
              // Only the first mismatch of a walk is recorded.
              if (!err_q && cap_q != ent_q[DATA_W-1:0]) begin
                err_d     = 1'b1;
                err_idx_d = idx_q;
              end
              state_d = S_NEXT;
            end
`else
            end else begin
              state_d = S_NEXT;
            end
`endif
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          rd_d    = 1'b0;
          state_d = S_ROM_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRESET_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_q      <= 1'b0;
      ent_q       <= '0;
      rd_q        <= 1'b0;
      cmd_q       <= 1'b0;
      ret_done_q  <= 1'b0;
      sr_q        <= '0;
      cap_q       <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      ent_q       <= ent_d;
      rd_q        <= rd_d;
      cmd_q       <= cmd_d;
      ret_done_q  <= ret_done_d;
      sr_q        <= sr_d;
      cap_q       <= cap_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign oROM_ADDR      = idx_q;
  assign oBUSY          = busy_q;
  assign oDONE          = done_q;
  assign oERR           = err_q;
  assign oERR_IDX       = err_idx_q;
  assign oCS_n          = cs_n_q;
  assign oSCLK          = sclk_q;
  assign oDIN           = din_q;
  assign cmd.oCMD_READY = iRESET_n && accept;
  assign cmd.oRSP_VALID = rsp_valid_q;
  assign cmd.oRSP_RDATA = rsp_rdata_q;
endmodule

// File: tb/tb_audio_spi_reg_engine.sv
// Bench for audio_spi_reg_engine: codec SPI slave model, sync ROM, host command vectors and table walks.
module tb_audio_spi_reg_engine;
  localparam int CLK_DIV = 2;
  localparam int NW      = 4;
`ifdef VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [14:0] rom_data = '0;
  logic        busy, done, err;
  logic [7:0]  err_idx;
  logic        cs_n, sclk, din;
  logic        dout = 1'b1;

  audio_spi_reg_engine_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  audio_spi_reg_engine #(
    .ADDR_W(7), .DATA_W(8), .NUM_WORDS(NW), .IDX_W(8), .CLK_DIV(CLK_DIV), .GAP_TICKS(2)
  ) dut (
    .iCLK_50(clk), .iRESET_n(rst_n), .iSTART(start),
    .oROM_ADDR(rom_addr), .iROM_DATA(rom_data), .cmd(bus),
    .oBUSY(busy), .oDONE(done), .oERR(err), .oERR_IDX(err_idx),
    .oCS_n(cs_n), .oSCLK(sclk), .oDIN(din), .iDOUT(dout)
  );

  always #5 clk = ~clk;

  logic [14:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Codec model: records frames, applies writes, answers reads in the data phase.
  logic [7:0]  codec_regs [0:127];
  logic        corrupt_en = 1'b0;
  logic [6:0]  corrupt_addr = '0;
  logic        cs_p = 1'b1, sclk_p = 1'b1;
  int          bits = 0;
  logic [15:0] fr = '0;
  logic [6:0]  c_addr = '0;
  logic [15:0] frames [$];
  int          cs_low_cyc = 0, last_low_cyc = 0;
  int          rsp_cnt = 0, rdy_busy = 0, rom_max = 0;
  logic [7:0]  rsp_last = '0;
  logic [7:0]  rd_byte;

  assign rd_byte = codec_regs[c_addr] ^ ((corrupt_en && c_addr == corrupt_addr) ? 8'hFF : 8'h00);

  initial for (int i = 0; i < 128; i++) codec_regs[i] <= (i == 'h22) ? 8'h3C : 8'(i * 3 + 1);

  always @(negedge clk) begin
    cs_p   <= cs_n;
    sclk_p <= sclk;
    if (bus.oRSP_VALID) begin
      rsp_cnt  <= rsp_cnt + 1;
      rsp_last <= bus.oRSP_RDATA;
    end
    if (bus.oCMD_READY && busy) rdy_busy <= rdy_busy + 1;
    if (int'(rom_addr) > rom_max) rom_max <= int'(rom_addr);
    if (cs_p && !cs_n) begin
      bits       <= 0;
      fr         <= '0;
      cs_low_cyc <= 1;
    end else if (!cs_n) begin
      cs_low_cyc <= cs_low_cyc + 1;
      if (!sclk_p && sclk) begin
        fr   <= {fr[14:0], din};
        bits <= bits + 1;
        if (bits == 7) c_addr <= fr[6:0];
      end else if (sclk_p && !sclk && bits >= 8 && bits < 16) begin
        dout <= rd_byte[3'(15 - bits)];
      end
    end else if (!cs_p && cs_n) begin
      last_low_cyc <= cs_low_cyc;
      if (bits == 16) begin
        frames.push_back(fr);
        if (!fr[8]) codec_regs[fr[15:9]] <= fr[7:0];
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d, output logic acc);
    bus.iCMD_RW = rw; bus.iCMD_ADDR = a; bus.iCMD_WDATA = d; bus.iCMD_VALID = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 3000 && !acc; n++) begin
      #1;
      acc = bus.oCMD_READY;
      @(posedge clk); #1;
    end
    bus.iCMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (!busy) ok = 1'b1;
      else cyc(1);
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      if (done) ok = 1'b1;
      else cyc(1);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_frame;
    logic        exp_rsp;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t        vt [10];
  logic [7:0]  ref_regs [0:127];
  logic [6:0]  wa [NW];
  logic [7:0]  wd [NW];
  logic [15:0] exp_q [$];

  // Reference walk: one write frame per entry, plus a readback frame when checking is built in.
  task automatic build_walk();
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back({wa[i], 1'b0, wd[i]});
      if (VER == 1) exp_q.push_back({wa[i], 1'b1, 8'hFF});
      ref_regs[wa[i]] = wd[i];
    end
  endtask

  task automatic check_walk(input int f0, input logic exp_err, input logic [7:0] exp_eidx);
    chk("walk_nframes", frames.size() - f0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (f0 + i < frames.size()) chk($sformatf("walk_frame%0d", i), frames[f0+i], exp_q[i]);
    chk("walk_busy", busy, 0);
    chk("walk_rom_addr", rom_addr, NW - 1);
    chk("walk_rom_max", rom_max, NW - 1);
    chk("walk_err", err, exp_err);
    chk("walk_err_idx", err_idx, exp_eidx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok, acc;
    int f0, r0, rb0;

    bus.iCMD_VALID = 0; bus.iCMD_RW = 0; bus.iCMD_ADDR = '0; bus.iCMD_WDATA = '0;
    for (int i = 0; i < 128; i++) ref_regs[i] = (i == 'h22) ? 8'h3C : 8'(i * 3 + 1);
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < NW; i++) begin
      wa[i] = 7'(8'h40 + i * 9);
      wd[i] = 8'($urandom);
      rom[i] = {wa[i], wd[i]};
    end

    vt[0] = '{rw: 0, addr: 7'h05, wdata: 8'hA5, exp_frame: 16'h0AA5, exp_rsp: 0, exp_rdata: 0};
    vt[1] = '{rw: 1, addr: 7'h22, wdata: 8'h00, exp_frame: 16'h45FF, exp_rsp: 1, exp_rdata: 8'h3C};
    vt[2] = '{rw: 1, addr: 7'h05, wdata: 8'h00, exp_frame: 16'h0BFF, exp_rsp: 1, exp_rdata: 8'hA5};
    ref_regs[7'h05] = 8'hA5;
    for (int i = 3; i < 10; i++) begin
      vt[i].rw    = 1'($urandom_range(0, 1));
      vt[i].addr  = 7'($urandom_range(0, 63));
      vt[i].wdata = 8'($urandom);
      vt[i].exp_frame = {vt[i].addr, vt[i].rw, vt[i].rw ? 8'hFF : vt[i].wdata};
      vt[i].exp_rsp   = vt[i].rw;
      vt[i].exp_rdata = vt[i].rw ? ref_regs[vt[i].addr] : 8'h00;
      if (!vt[i].rw) ref_regs[vt[i].addr] = vt[i].wdata;
    end

    // Reset state
    cyc(3);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_valid", bus.oRSP_VALID, 0);
    rst_n = 1'b1;
    cyc(2);

    // Host command vectors
    for (int i = 0; i < 10; i++) begin
      f0 = frames.size(); r0 = rsp_cnt;
      do_cmd(vt[i].rw, vt[i].addr, vt[i].wdata, acc);
      chk($sformatf("v%0d_ready", i), acc, 1);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_idle(ok);
      chk($sformatf("v%0d_idle", i), ok, 1);
      cyc(2);
      chk($sformatf("v%0d_nframes", i), frames.size() - f0, 1);
      if (frames.size() > f0) chk($sformatf("v%0d_frame", i), frames[f0], vt[i].exp_frame);
      chk($sformatf("v%0d_cs_low", i), last_low_cyc, 34 * CLK_DIV);
      chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt - r0, vt[i].exp_rsp);
      if (vt[i].exp_rsp) chk($sformatf("v%0d_rdata", i), rsp_last, vt[i].exp_rdata);
      chk($sformatf("v%0d_done", i), done, 0);
    end

    // iSTART and a read command in the same IDLE cycle: walk first, command afterwards
    build_walk();
    f0 = frames.size(); rb0 = rdy_busy; r0 = rsp_cnt;
    start = 1'b1;
    bus.iCMD_RW = 1'b1; bus.iCMD_ADDR = 7'h05; bus.iCMD_WDATA = 8'h00; bus.iCMD_VALID = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("walk1_busy_start", busy, 1);
    wait_done(ok);
    chk("walk1_done", ok, 1);
    chk("walk1_no_ready_busy", rdy_busy - rb0, 0);
    check_walk(f0, 1'b0, 8'h00);
    f0 = frames.size();
    do_cmd(1'b1, 7'h05, 8'h00, acc);
    chk("pend_ready", acc, 1);
    wait_idle(ok);
    cyc(2);
    chk("pend_frame", (frames.size() > f0) ? frames[f0] : 16'h0000, 16'h0BFF);
    chk("pend_rsp_cnt", rsp_cnt - r0, 1);
    chk("pend_rdata", rsp_last, 8'hA5);
    chk("pend_done_sticky", done, 1);

    // Codec returns a wrong byte for entry 2 only
    corrupt_addr = wa[2]; corrupt_en = 1'b1;
    build_walk();
    f0 = frames.size();
    start = 1'b1; cyc(1); start = 1'b0;
    chk("walk2_done_clr", done, 0);
    wait_done(ok);
    chk("walk2_done", ok, 1);
    check_walk(f0, (VER == 1), (VER == 1) ? 8'd2 : 8'd0);
    corrupt_en = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    chk("walk3_err_clr", err, 0);
    f0 = frames.size();
    wait_done(ok);
    chk("walk3_done", ok, 1);
    check_walk(f0, 1'b0, 8'h00);

    // Reset during bit 7 of a frame
    do_cmd(1'b0, 7'h33, 8'h0F, acc);
    chk("mid_ready", acc, 1);
    for (int n = 0; n < 500 && !(bits == 6 && !sclk && !cs_n); n++) cyc(1);
    chk("mid_in_bit7", (bits == 6 && !sclk && !cs_n), 1);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_cs_n", cs_n, 1);
    chk("mid_sclk", sclk, 1);
    chk("mid_din", din, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_rom_addr", rom_addr, 0);
    chk("mid_rsp_rdata", bus.oRSP_RDATA, 0);
    chk("mid_ready_low", bus.oCMD_READY, 0);
    rst_n = 1'b1;
    cyc(3);
    f0 = frames.size(); r0 = rsp_cnt;
    do_cmd(1'b1, 7'h33, 8'h00, acc);
    wait_idle(ok);
    cyc(2);
    chk("post_rst_frame", (frames.size() > f0) ? frames[f0] : 16'h0000, {7'h33, 1'b1, 8'hFF});
    chk("post_rst_rdata", rsp_last, ref_regs[7'h33]);
    chk("post_rst_rsp_cnt", rsp_cnt - r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
